// File: rtl/fre_meter.sv
`default_nettype none
// ============================================================================
// fre_meter : measures period and high time of a slow signal in clk_in cycles
// Revision  : 1.0
// ============================================================================
module fre_meter #(
  parameter int              WIDTH   = 26,
  parameter logic [WIDTH-1:0] MAX_CNT = {WIDTH{1'b1}}
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             overrun,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    WAIT_RISE = 2'd1,
    HIGH      = 2'd2,
    LOW       = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             sig_d;
  logic             rise;
  logic             fall;
  logic [WIDTH-1:0] pcnt;
  logic [WIDTH-1:0] hcnt;
  logic [WIDTH-1:0] pcnt_nxt;
  logic [WIDTH-1:0] hcnt_nxt;
  logic [WIDTH-1:0] pcnt_inc;
  logic             complete;
  logic             tmo_hit;
  logic             transfer;

  assign rise     = sig_in & ~sig_d;
  assign fall     = ~sig_in & sig_d;
  assign pcnt_inc = (pcnt == MAX_CNT) ? pcnt : pcnt + C_ONE;
  assign transfer = meas_valid & meas_ready;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARM;
      sig_d <= 1'b0;
      pcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      sig_d <= sig_in;
      pcnt  <= pcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Only a fall can occur in HIGH and only a rise in LOW, since each state is
  // entered on the opposite edge.
  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    hcnt_nxt  = hcnt;
    complete  = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ARM: begin
        if (!sig_in) state_nxt = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          pcnt_nxt  = C_ONE;
          hcnt_nxt  = C_ONE;
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          pcnt_nxt  = pcnt_inc;
          state_nxt = LOW;
        end else if (pcnt == MAX_CNT) begin
          tmo_hit   = 1'b1;
          state_nxt = ARM;
        end else begin
          pcnt_nxt = pcnt_inc;
          hcnt_nxt = hcnt + C_ONE;
        end
      end
      LOW: begin
        if (rise) begin
          complete  = 1'b1;
          pcnt_nxt  = C_ONE;
          hcnt_nxt  = C_ONE;
          state_nxt = HIGH;
        end else if (pcnt == MAX_CNT) begin
          tmo_hit   = 1'b1;
          state_nxt = ARM;
        end else begin
          pcnt_nxt = pcnt_inc;
        end
      end
      default: state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      period_out <= '0;
      high_out   <= '0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      if (complete && (!meas_valid || meas_ready)) begin
        meas_valid <= 1'b1;
        period_out <= pcnt;
        high_out   <= hcnt;
      end else if (transfer) begin
        meas_valid <= 1'b0;
      end

      // A drop needs meas_ready low, so it can never coincide with a transfer.
      if (complete && meas_valid && !meas_ready) begin
        overrun <= 1'b1;
      end else if (transfer) begin
        overrun <= 1'b0;
      end

      if (tmo_hit) begin
        timeout <= 1'b1;
      end else if (complete) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fre_meter.sv
`default_nettype none
// Testbench for fre_meter: directed sig_in patterns, expected results queued
// by the stimulus and checked by a monitor on every output transfer.
module tb_fre_meter;
  localparam int W = 26;

  logic         clk_in     = 1'b0;
  logic         rst_n      = 1'b0;
  logic         sig_in     = 1'b0;
  logic         meas_ready = 1'b0;
  logic         meas_valid;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         overrun;
  logic         timeout;

  typedef struct packed {
    logic [W-1:0] p;
    logic [W-1:0] h;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  fre_meter #(.WIDTH(W), .MAX_CNT(26'd20)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .sig_in     (sig_in),
    .meas_ready (meas_ready),
    .meas_valid (meas_valid),
    .period_out (period_out),
    .high_out   (high_out),
    .overrun    (overrun),
    .timeout    (timeout)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int p, input int h);
    res_t r;
    r.p = W'(p);
    r.h = W'(h);
    exp_q.push_back(r);
  endtask

  // Drive one sample of sig_in and return just after the edge that samples it.
  task automatic cyc(input logic s);
    sig_in = s;
    @(posedge clk_in);
    #1;
  endtask

  task automatic run(input logic s, input int n);
    repeat (n) cyc(s);
  endtask

  task automatic do_reset(input logic s);
    rst_n  = 1'b0;
    sig_in = s;
    repeat (2) @(posedge clk_in);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every transfer must match the oldest queued expectation.
  res_t got_exp;
  always @(negedge clk_in) begin
    if (rst_n && meas_valid && meas_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d/%0d expected none", period_out, high_out);
      end else begin
        got_exp = exp_q.pop_front();
        chk("period_out", period_out, got_exp.p);
        chk("high_out", high_out, got_exp.h);
      end
    end
  end

  initial begin
    meas_ready = 1'b1;
    rst_n      = 1'b0;
    sig_in     = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_valid", W'(meas_valid), '0);
    chk("rst_period", period_out, '0);
    chk("rst_high", high_out, '0);
    chk("rst_overrun", W'(overrun), '0);
    chk("rst_timeout", W'(timeout), '0);
    rst_n = 1'b1;

    // Divider pattern: 3 low, 3 high
    run(1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) push(6, 3);
      run(1'b1, 3);
      run(1'b0, 3);
    end
    chk("div_overrun", W'(overrun), '0);
    chk("div_timeout", W'(timeout), '0);
    chk("div_queue", W'(exp_q.size()), '0);

    // Toggling every cycle: minimum period
    do_reset(1'b0);
    run(1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) push(2, 1);
      cyc(1'b1);
      cyc(1'b0);
    end
    run(1'b0, 2);
    chk("tog_queue", W'(exp_q.size()), '0);

    // High at reset release: partial first high must be ignored
    do_reset(1'b1);
    run(1'b1, 3);
    run(1'b0, 6);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) push(10, 4);
      run(1'b1, 4);
      run(1'b0, 6);
    end
    chk("arm_queue", W'(exp_q.size()), '0);

    // Overrun: two completions while the consumer stalls
    do_reset(1'b0);
    meas_ready = 1'b0;
    run(1'b0, 3);
    run(1'b1, 3);
    run(1'b0, 3);
    push(6, 3);
    run(1'b1, 3);
    run(1'b0, 3);
    cyc(1'b1);
    chk("ovr_valid", W'(meas_valid), W'(1));
    chk("ovr_period_held", period_out, W'(6));
    chk("ovr_high_held", high_out, W'(3));
    chk("ovr_set", W'(overrun), W'(1));
    meas_ready = 1'b1;
    cyc(1'b1);
    meas_ready = 1'b0;
    chk("ovr_valid_drop", W'(meas_valid), '0);
    chk("ovr_clear", W'(overrun), '0);
    chk("ovr_period_keep", period_out, W'(6));
    cyc(1'b1);
    run(1'b0, 3);
    push(6, 3);
    cyc(1'b1);
    chk("ovr_next_valid", W'(meas_valid), W'(1));
    chk("ovr_next_overrun", W'(overrun), '0);
    meas_ready = 1'b1;
    cyc(1'b1);
    chk("ovr_queue", W'(exp_q.size()), '0);

    // Timeout at MAX_CNT=20 with sig_in stuck low after one rise
    do_reset(1'b0);
    run(1'b0, 2);
    cyc(1'b1);
    run(1'b0, 19);
    chk("tmo_before", W'(timeout), '0);
    cyc(1'b0);
    chk("tmo_set", W'(timeout), W'(1));
    run(1'b0, 3);
    run(1'b1, 3);
    run(1'b0, 3);
    chk("tmo_sticky", W'(timeout), W'(1));
    push(6, 3);
    cyc(1'b1);
    chk("tmo_clear", W'(timeout), '0);
    run(1'b1, 2);
    run(1'b0, 2);
    chk("tmo_queue", W'(exp_q.size()), '0);

    // Asynchronous reset mid-HIGH with a pending result
    do_reset(1'b0);
    meas_ready = 1'b0;
    run(1'b0, 2);
    run(1'b1, 3);
    run(1'b0, 3);
    cyc(1'b1);
    cyc(1'b1);
    chk("ares_pre_valid", W'(meas_valid), W'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("ares_valid", W'(meas_valid), '0);
    chk("ares_period", period_out, '0);
    chk("ares_high", high_out, '0);
    chk("ares_overrun", W'(overrun), '0);
    chk("ares_timeout", W'(timeout), '0);
    @(posedge clk_in);
    #1;
    sig_in     = 1'b1;
    rst_n      = 1'b1;
    meas_ready = 1'b1;
    run(1'b1, 2);
    run(1'b0, 3);
    run(1'b1, 3);
    run(1'b0, 3);
    push(6, 3);
    cyc(1'b1);
    run(1'b1, 2);
    run(1'b0, 3);
    chk("final_queue", W'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fre_meter.md
# fre_meter

Measures the period and high time of a slow periodic signal, such as the divided clock from our frequency divider, sampled in the fast source-clock domain. It counts source-clock cycles between consecutive rising edges and during the high phase. Each completed measurement is presented on a valid/ready output port. It is the checker stage placed downstream of the divider, and it feeds status/readout logic.

## Interface
- WIDTH, 26: width of the internal counters and of period_out/high_out.
- MAX_CNT, 2^WIDTH-1: period-count limit; reaching it without a rising edge is a timeout.

- clk_in  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- sig_in  input  1  measured signal, synchronous to clk_in (e.g. divider clk_out).
- meas_ready  input  1  consumer accepts the current result at a clk_in edge when high.
- meas_valid  output  1  period_out/high_out hold an unconsumed result.
- period_out  output  WIDTH  clk_in cycles from one rising edge of sig_in to the next.
- high_out  output  WIDTH  clk_in cycles with sig_in sampled 1 within that period.
- overrun  output  1  sticky: a result was dropped because the previous one was not accepted.
- timeout  output  1  period count reached MAX_CNT without a rising edge.

## Operation
- Edge detect:
  - sig_d is a registered copy of sig_in; reset value 0.
  - rise = sig_in & ~sig_d.
  - fall = ~sig_in & sig_d.
- Counters:
  - pcnt (period) and hcnt (high), both WIDTH bits, reset 0.
  - pcnt saturates at MAX_CNT and never wraps.
- FSM states: ARM, WAIT_RISE, HIGH, LOW. Reset state is ARM.
  - ARM: wait for sig_in==0, then go to WAIT_RISE. This avoids timing a partial first period.
  - WAIT_RISE: on rise, set pcnt<=1 and hcnt<=1, go to HIGH. No timeout in this state.
  - HIGH: pcnt+1 and hcnt+1 each cycle. On fall, pcnt+1 with hcnt held, go to LOW.
  - LOW: pcnt+1 each cycle. On rise the measurement completes:
    - result = (pcnt, hcnt) as they are before that edge;
    - restart with pcnt<=1, hcnt<=1, stay in the measurement loop and go to HIGH (back-to-back measurements, no gap).
  - HIGH/LOW: when pcnt==MAX_CNT and no edge occurs this cycle:
    - set timeout<=1, go to ARM;
    - the in-progress measurement is discarded.
- Output handshake:
  - A transfer occurs at an edge where meas_valid && meas_ready; the result is consumed.
  - On completion when meas_valid==0, or when a transfer occurs at the same edge: load period_out/high_out and set meas_valid<=1.
  - On completion when meas_valid==1 && meas_ready==0: drop the new result, set overrun<=1, leave outputs untouched.
  - On a transfer with no completion at the same edge: meas_valid<=0. period_out/high_out keep their last value.
  - overrun clears on the next transfer unless a drop occurs at that same edge; a drop wins.
  - timeout clears on the next completed measurement, whether loaded or dropped.
- Reset (asynchronous, any time, including mid-measurement):
  - all outputs 0, counters 0, sig_d 0, state ARM;
  - any pending result is lost.

## Timing
- Completion latency: result registered at the clk_in edge that samples the rising edge. meas_valid, period_out and high_out are visible one cycle after sig_in is first sampled high.
- Minimum measurable period: 2 cycles (high 1, low 1).
- For a signal with high time H and period P cycles: period_out=P, high_out=H.
- Throughput: one result per period of sig_in. The consumer must accept within P cycles to avoid overrun.
- meas_valid stays high until a transfer. Outputs are stable while meas_valid && !meas_ready.

## Test plan
- Divider pattern (3 low, 3 high, repeating), meas_ready=1 -> first result after the second rise seen. period_out=6, high_out=3, meas_valid pulses once per 6 cycles, overrun=0.
- sig_in toggling every cycle, meas_ready=1 -> period_out=2, high_out=1 every 2 cycles.
- sig_in high at reset release, then period 10 / high 4 -> ARM ignores the first partial high. The first result is 10/4, with no bogus shorter value.
- meas_ready=0 across two completions of a 6/3 pattern -> first result held on the outputs, overrun=1. Then raise meas_ready for one cycle -> transfer occurs, meas_valid drops until the next completion, overrun=0.
- MAX_CNT=20, sig_in stuck 0 after one rise -> timeout=1 when pcnt hits 20, FSM in ARM. Restart the 6/3 pattern -> one result 6/3, timeout clears.
- rst_n asserted mid-HIGH with meas_valid=1 -> all outputs 0 immediately (asynchronously). After release, measurement restarts from ARM.
